pe_sad_row: RTL and testbench
=============================

// Module: pe_sad_row
// PURPOSE
//  Parametrised row of NPE systolic SAD processing elements for integer motion estimation.
//  Each lane holds one current-block pixel (CPR) and one search-area pixel (SPR); SPR loads from above/down/right-shift or holds.
//  Per-lane |CPR-SPR| feeds a registered adder tree; row sums accumulate over ROWS rows into one block SAD with a valid pulse.
//  Sits between the search-window memory/scan controller and the SAD comparator (min-SAD / MV select).
// PARAMETERS
//  PIXWIDTH  8   pixel width in bits
//  NPE       16  lanes per row (power of 2, >=2)
//  ROWS      16  rows per block SAD (power of 2, >=2)
//  localparam RSW  = PIXWIDTH+$clog2(NPE)   row-sum width (12 at defaults)
//  localparam ACCW = RSW+$clog2(ROWS)       block-SAD width (16 at defaults)
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              reset, asynchronous, active-low
//  en         in   1              row valid: load lanes this cycle; 0 = bubble, lanes hold
//  first      in   1              qualifies en: this row is row 0 of a new block
//  sel        in   2              SPR source: 00 above, 01 down, 10 right-shift, 11 hold
//  cpr_in     in   NPE*PIXWIDTH   current pixels, lane i at [i*PIXWIDTH +: PIXWIDTH]
//  pe_above   in   NPE*PIXWIDTH   SPR source for sel=00
//  pe_down    in   NPE*PIXWIDTH   SPR source for sel=01
//  right_in   in   PIXWIDTH       shift-in for lane NPE-1 when sel=10
//  spr_out    out  NPE*PIXWIDTH   lane SPR registers
//  cpr_out    out  NPE*PIXWIDTH   lane CPR registers
//  row_sad    out  RSW            registered row sum (stage 3)
//  sad        out  ACCW           block SAD, valid with sad_valid, held until next result
//  sad_valid  out  1              one-cycle pulse per completed block
//  busy       out  1              1 while a block is accumulating (ACC state)
// BEHAVIOUR
//  Reset (rst=0, async): all CPR/SPR, pipeline, counters, row_sad, sad = 0; sad_valid=0; busy=0; state IDLE.
//  Stage 1 (edge where en=1): CPR[i]<=cpr_in[i]; SPR[i]<= above[i] | down[i] | SPR[i+1] (right; lane NPE-1 <= right_in) | SPR[i] (hold).
//   Right-shift uses pre-edge SPR values. en=0: CPR and SPR hold regardless of sel.
//  Stage 2: AD[i] <= |CPR[i]-SPR[i]|, computed in PIXWIDTH+1 bits, result fits PIXWIDTH (max 2^PIXWIDTH-1).
//  Stage 3: row_sad <= sum of AD[0..NPE-1] (zero-extended, no truncation).
//  en and first ride a valid/first shift pipe beside the data; bubbles propagate as invalid, accumulator holds.
//  Latency: row loaded at edge k -> AD at k+1 -> row_sad at k+2 -> sad/sad_valid at k+3 (last row).
//  Accumulator FSM (acts on stage-3 valid rows only):
//   IDLE: valid&first -> acc<=row_sad, cnt<=1, ACC. Valid rows without first are ignored.
//   ACC: valid&first -> restart (acc<=row_sad, cnt<=1); partial block discarded, no pulse.
//        valid&!first&cnt==ROWS-1 -> sad<=acc+row_sad, sad_valid<=1, IDLE.
//        valid&!first otherwise -> acc+=row_sad, cnt++.
//  A valid first row in the same cycle a block completes cannot happen (one row per cycle); first always wins.
//  ACCW sized for worst case: no overflow, no saturation.
//  sad_valid is high exactly one cycle; sad holds last result until next completion or reset.
//  Reset mid-block: everything cleared; in-flight rows lost; no pulse.
// STRUCTURE
//  Package pe_pkg: typedef enum logic [1:0] {SEL_ABOVE, SEL_DOWN, SEL_RIGHT, SEL_HOLD} pe_sel_e;
//   typedef enum logic {ACC_IDLE, ACC_RUN} acc_state_e.
//  Sub-module pe_lane: one lane (CPR/SPR regs, 4:1 SPR mux, registered abs-diff); generated NPE times.
//  Top: lane generate loop, pipelined adder tree, valid/first pipe, accumulator FSM.
// TESTING (defaults: PIXWIDTH=8, NPE=16, ROWS=16)
//  Uniform: cpr=10, above=3 all lanes, sel=00, first on row 0, 16 rows en=1 -> one pulse 3 cycles after last row, sad=1792.
//  Abs/extreme: cpr=0, above=255 every row -> row_sad=4080, sad=65280, no wrap; swap cpr/spr -> same result.
//  Right shift: load above lane i=i, then sel=10, right_in=99 -> spr_out lane i=i+1, lane 15=99; sel=11 -> unchanged.
//  Bubbles: 16 valid rows interleaved with random en=0 gaps -> same sad as contiguous run, single pulse.
//  Restart: first re-asserted at row 8 -> no pulse for aborted block; pulse 16 valid rows after second first.
//  Async reset mid-block: rst=0 between edges -> outputs 0 at once, busy=0; post-reset rows without first ignored.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types for the systolic SAD row: SPR source select and accumulator states.
package pe_pkg;

  typedef enum logic [1:0] {
    SEL_ABOVE = 2'b00,
    SEL_DOWN  = 2'b01,
    SEL_RIGHT = 2'b10,
    SEL_HOLD  = 2'b11
  } pe_sel_e;

  typedef enum logic {
    ACC_IDLE = 1'b0,
    ACC_RUN  = 1'b1
  } acc_state_e;

endpackage

// File: rtl/pe_lane.sv
// One SAD lane: current/search pixel registers, 4:1 SPR source mux, registered |CPR-SPR|.
module pe_lane
  import pe_pkg::*;
#(
  parameter int unsigned PIXWIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  pe_sel_e             sel,
  input  logic [PIXWIDTH-1:0] cpr_in,
  input  logic [PIXWIDTH-1:0] above,
  input  logic [PIXWIDTH-1:0] down,
  input  logic [PIXWIDTH-1:0] right_nb,
  output logic [PIXWIDTH-1:0] cpr,
  output logic [PIXWIDTH-1:0] spr,
  output logic [PIXWIDTH-1:0] ad
);

  logic [PIXWIDTH-1:0] spr_nxt;
  logic [PIXWIDTH:0]   diff;
  logic [PIXWIDTH-1:0] ad_nxt;

  always_comb begin
    spr_nxt = spr;
    case (sel)
      SEL_ABOVE: spr_nxt = above;
      SEL_DOWN:  spr_nxt = down;
      SEL_RIGHT: spr_nxt = right_nb;
      default:   spr_nxt = spr;
    endcase
  end

  // Difference in one extra bit; the magnitude always fits back into PIXWIDTH.
  always_comb begin
    diff   = {1'b0, cpr} - {1'b0, spr};
    ad_nxt = diff[PIXWIDTH] ? PIXWIDTH'(~diff + (PIXWIDTH+1)'(1)) : diff[PIXWIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpr <= '0;
      spr <= '0;
      ad  <= '0;
    end else begin
      if (en) begin
        cpr <= cpr_in;
        spr <= spr_nxt;
      end
      ad <= ad_nxt;
    end
  end

endmodule

// File: rtl/pe_sad_row.sv
// Row of NPE SAD lanes with a registered row sum and a block accumulator that
// emits one SAD per ROWS valid rows.
module pe_sad_row
  import pe_pkg::*;
#(
  parameter  int unsigned PIXWIDTH = 8,
  parameter  int unsigned NPE      = 16,
  parameter  int unsigned ROWS     = 16,
  localparam int unsigned RSW      = PIXWIDTH + $clog2(NPE),
  localparam int unsigned ACCW     = RSW + $clog2(ROWS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    first,
  input  logic [1:0]              sel,
  input  logic [NPE*PIXWIDTH-1:0] cpr_in,
  input  logic [NPE*PIXWIDTH-1:0] pe_above,
  input  logic [NPE*PIXWIDTH-1:0] pe_down,
  input  logic [PIXWIDTH-1:0]     right_in,
  output logic [NPE*PIXWIDTH-1:0] spr_out,
  output logic [NPE*PIXWIDTH-1:0] cpr_out,
  output logic [RSW-1:0]          row_sad,
  output logic [ACCW-1:0]         sad,
  output logic                    sad_valid,
  output logic                    busy
);

  localparam int unsigned CNTW = $clog2(ROWS);

  logic [PIXWIDTH-1:0] ad [NPE];

  for (genvar i = 0; i < int'(NPE); i++) begin : g_lane
    logic [PIXWIDTH-1:0] nb;
    if (i == int'(NPE) - 1) begin : g_edge
      assign nb = right_in;
    end else begin : g_mid
      assign nb = spr_out[(i+1)*PIXWIDTH +: PIXWIDTH];
    end

    pe_lane #(.PIXWIDTH(PIXWIDTH)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .sel      (pe_sel_e'(sel)),
      .cpr_in   (cpr_in[i*PIXWIDTH +: PIXWIDTH]),
      .above    (pe_above[i*PIXWIDTH +: PIXWIDTH]),
      .down     (pe_down[i*PIXWIDTH +: PIXWIDTH]),
      .right_nb (nb),
      .cpr      (cpr_out[i*PIXWIDTH +: PIXWIDTH]),
      .spr      (spr_out[i*PIXWIDTH +: PIXWIDTH]),
      .ad       (ad[i])
    );
  end

  logic [RSW-1:0] row_sum;

  always_comb begin
    row_sum = '0;
    for (int i = 0; i < int'(NPE); i++) row_sum = row_sum + RSW'(ad[i]);
  end

  // Valid/first travel alongside the data: lane regs, AD regs, row_sad.
  logic v1, v2, v3, f1, f2, f3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {v1, v2, v3} <= '0;
      {f1, f2, f3} <= '0;
      row_sad      <= '0;
    end else begin
      v1      <= en;
      f1      <= first;
      v2      <= v1;
      f2      <= f1;
      v3      <= v2;
      f3      <= f2;
      row_sad <= row_sum;
    end
  end

  acc_state_e      state, state_nxt;
  logic [ACCW-1:0] acc, acc_nxt, sad_nxt;
  logic [CNTW-1:0] cnt, cnt_nxt;
  logic            sad_valid_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ACC_IDLE;
      acc       <= '0;
      cnt       <= '0;
      sad       <= '0;
      sad_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      sad       <= sad_nxt;
      sad_valid <= sad_valid_nxt;
      busy      <= (state_nxt == ACC_RUN);
    end
  end

  // A valid first row always (re)starts a block, discarding any partial sum.
  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    cnt_nxt       = cnt;
    sad_nxt       = sad;
    sad_valid_nxt = 1'b0;
    case (state)
      ACC_IDLE: begin
        if (v3 && f3) begin
          acc_nxt   = ACCW'(row_sad);
          cnt_nxt   = CNTW'(1);
          state_nxt = ACC_RUN;
        end
      end
      ACC_RUN: begin
        if (v3) begin
          if (f3) begin
            acc_nxt = ACCW'(row_sad);
            cnt_nxt = CNTW'(1);
          end else if (cnt == CNTW'(ROWS - 1)) begin
            sad_nxt       = acc + ACCW'(row_sad);
            sad_valid_nxt = 1'b1;
            state_nxt     = ACC_IDLE;
          end else begin
            acc_nxt = acc + ACCW'(row_sad);
            cnt_nxt = cnt + CNTW'(1);
          end
        end
      end
      default: state_nxt = ACC_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pe_sad_row.sv
// Randomized scoreboard bench for pe_sad_row: an array-level model predicts row sums,
// busy and block SAD pulses; a negedge monitor compares against the DUT.
module tb_pe_sad_row;
  localparam int PW = 8;
  localparam int N  = 16;
  localparam int R  = 16;
  localparam int VW = N * PW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0, first = 1'b0;
  logic [1:0]    sel = 2'b11;
  logic [VW-1:0] cpr_in = '0, pe_above = '0, pe_down = '0;
  logic [PW-1:0] right_in = '0;
  logic [VW-1:0] spr_out, cpr_out;
  logic [11:0]   row_sad;
  logic [15:0]   sad;
  logic          sad_valid, busy;

  pe_sad_row #(.PIXWIDTH(PW), .NPE(N), .ROWS(R)) dut (
    .clk(clk), .rst(rst), .en(en), .first(first), .sel(sel),
    .cpr_in(cpr_in), .pe_above(pe_above), .pe_down(pe_down), .right_in(right_in),
    .spr_out(spr_out), .cpr_out(cpr_out), .row_sad(row_sad), .sad(sad),
    .sad_valid(sad_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  typedef struct {
    int cyc;
    int row;
    bit busy;
    bit pulse;
    int sad;
  } ev_t;
  ev_t evq[$];

  // Reference model: pixel arrays and block accumulation by plain integer arithmetic.
  int cpr_m[N];
  int spr_m[N];
  bit m_run;
  int m_acc, m_cnt, m_sad;

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      cpr_m[i] = 0;
      spr_m[i] = 0;
    end
    m_run = 0; m_acc = 0; m_cnt = 0; m_sad = 0;
  endfunction

  function automatic logic [VW-1:0] fill(int v);
    logic [VW-1:0] r;
    for (int i = 0; i < N; i++) r[i*PW +: PW] = PW'(v);
    return r;
  endfunction

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < N; i++) r[i*PW +: PW] = PW'($urandom_range(0, 255));
    return r;
  endfunction

  task automatic issue(bit e, bit f, logic [1:0] s, logic [VW-1:0] c,
                       logic [VW-1:0] a, logic [VW-1:0] d, int rin);
    int nspr[N];
    int rs, dlt;
    ev_t ev;
    @(negedge clk);
    en = e; first = f; sel = s; cpr_in = c; pe_above = a; pe_down = d;
    right_in = PW'(rin);
    if (e) begin
      for (int i = 0; i < N; i++) begin
        case (s)
          2'b00:   nspr[i] = int'(a[i*PW +: PW]);
          2'b01:   nspr[i] = int'(d[i*PW +: PW]);
          2'b10:   nspr[i] = (i == N - 1) ? rin : spr_m[i+1];
          default: nspr[i] = spr_m[i];
        endcase
      end
      rs = 0;
      for (int i = 0; i < N; i++) begin
        spr_m[i] = nspr[i];
        cpr_m[i] = int'(c[i*PW +: PW]);
        dlt = cpr_m[i] - spr_m[i];
        rs += (dlt < 0) ? -dlt : dlt;
      end
      ev.pulse = 0;
      if (f) begin
        m_acc = rs; m_cnt = 1; m_run = 1;
      end else if (m_run) begin
        if (m_cnt == R - 1) begin
          m_sad = m_acc + rs; ev.pulse = 1; m_run = 0;
        end else begin
          m_acc += rs; m_cnt++;
        end
      end
      ev.cyc = edge_cnt + 4; ev.row = rs; ev.busy = m_run; ev.sad = m_sad;
      evq.push_back(ev);
    end
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      en = 1'b0; first = 1'b0;
    end
  endtask

  task automatic do_reset_mid();
    @(negedge clk);
    en = 1'b0; first = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst sad", sad, 0);
    chk("rst sad_valid", sad_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst row_sad", row_sad, 0);
    chk("rst spr_out zero", (spr_out == '0), 1);
    chk("rst cpr_out zero", (cpr_out == '0), 1);
    evq.delete();
    model_clear();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: row_sad one cycle before each row's accumulator event, then busy/pulse/sad.
  always @(negedge clk) begin
    if (rst) begin
      foreach (evq[j]) if (evq[j].cyc == edge_cnt + 1) chk("row_sad", row_sad, evq[j].row);
      if (evq.size() > 0 && evq[0].cyc == edge_cnt) begin
        chk("busy", busy, evq[0].busy);
        chk("sad_valid", sad_valid, evq[0].pulse);
        if (evq[0].pulse) chk("sad", sad, evq[0].sad);
        void'(evq.pop_front());
      end else if (sad_valid) begin
        chk("spurious sad_valid", 1, 0);
      end
    end
  end

  initial begin
    #(200000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [VW-1:0] bc[R], ba[R], bd[R];
  logic [1:0]    bs[R];
  int            saved_sad;

  initial begin
    model_clear();
    #3;
    chk("init sad", sad, 0);
    chk("init busy", busy, 0);
    chk("init sad_valid", sad_valid, 0);
    @(negedge clk); rst = 1'b1;
    idle(2);

    // Uniform block
    for (int r = 0; r < R; r++) issue(1, r == 0, 2'b00, fill(10), fill(3), '0, 0);
    idle(5);
    chk("uniform sad", sad, 1792);

    // Extreme values, then swapped operands
    for (int r = 0; r < R; r++) issue(1, r == 0, 2'b00, fill(0), fill(255), '0, 0);
    idle(5);
    chk("extreme sad", sad, 65280);
    chk("extreme row_sad held", row_sad, 4080);
    for (int r = 0; r < R; r++) issue(1, r == 0, 2'b00, fill(255), fill(0), '0, 0);
    idle(5);
    chk("swapped sad", sad, 65280);

    // Right shift and hold
    begin
      logic [VW-1:0] ramp;
      for (int i = 0; i < N; i++) ramp[i*PW +: PW] = PW'(i);
      issue(1, 0, 2'b00, fill(7), ramp, '0, 0);
      issue(1, 0, 2'b10, fill(7), fill(200), fill(201), 99);
      idle(1);
      for (int i = 0; i < N; i++)
        chk($sformatf("shift lane%0d", i), spr_out[i*PW +: PW], (i == N - 1) ? 99 : i + 1);
      issue(1, 0, 2'b11, fill(8), fill(200), fill(201), 55);
      idle(1);
      for (int i = 0; i < N; i++)
        chk($sformatf("hold lane%0d", i), spr_out[i*PW +: PW], spr_m[i]);
      chk("hold cpr lane0", cpr_out[PW-1:0], 8);
      idle(4);
    end

    // Same block contiguous, then with random bubbles
    for (int r = 0; r < R; r++) begin
      bc[r] = rnd_vec(); ba[r] = rnd_vec(); bd[r] = rnd_vec();
      bs[r] = 2'($urandom_range(0, 1));
    end
    for (int r = 0; r < R; r++) issue(1, r == 0, bs[r], bc[r], ba[r], bd[r], 0);
    idle(5);
    saved_sad = m_sad;
    for (int r = 0; r < R; r++) begin
      idle($urandom_range(0, 2));
      issue(1, r == 0, bs[r], bc[r], ba[r], bd[r], 0);
    end
    idle(5);
    chk("bubble sad equals contiguous", sad, saved_sad);

    // Restart at row 8
    for (int r = 0; r < 8; r++) issue(1, r == 0, 2'b00, rnd_vec(), rnd_vec(), '0, 0);
    for (int r = 0; r < R; r++) issue(1, r == 0, 2'b01, rnd_vec(), '0, rnd_vec(), 0);
    idle(5);

    // Async reset mid-block; rows without first are ignored afterwards
    for (int r = 0; r < 6; r++) issue(1, r == 0, 2'b00, rnd_vec(), rnd_vec(), '0, 0);
    do_reset_mid();
    for (int r = 0; r < 3; r++) issue(1, 0, 2'b00, rnd_vec(), rnd_vec(), '0, 0);
    idle(5);
    chk("post-reset busy", busy, 0);
    chk("post-reset sad", sad, 0);

    // Random mix
    for (int k = 0; k < 300; k++) begin
      issue($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
            2'($urandom_range(0, 3)), rnd_vec(), rnd_vec(), rnd_vec(),
            $urandom_range(0, 255));
    end
    idle(6);

    chk("scoreboard drained", evq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
